uart_packet_tx: RTL and testbench

Parametrised packet serializer between a wide application word and the byte-level UART transmitter. It generalises the fixed 32-bit "ToPC" send path to any payload width. It frames each packet as a header byte, the payload bytes LSB-first, and an optional modulo-256 checksum. Each byte is handed to the byte sender over a 4-phase send/send_done handshake, with a watchdog timeout. It sits in the qu_clk domain between application logic (camera/keyboard detection results) and the uart byte sender.

---
 rtl/uart_packet_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_packet_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// Packet serializer: frames a wide payload as header, payload bytes LSB-first and an optional
// modulo-256 checksum, handing each byte to the UART byte sender over a 4-phase handshake.
module uart_packet_tx #(
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter bit          CHECKSUM_EN   = 1'b1,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       send,
    input  logic [8*PAYLOAD_BYTES-1:0] data,
    output logic                       busy,
    output logic                       send_done,
    output logic                       error,
    output logic                       uart_send,
    output logic [7:0]                 uart_send_data,
    input  logic                       uart_send_done,
    output logic [3:0]                 sta,
    output logic [7:0]                 byte_idx
);

    localparam int unsigned NumBytes = 1 + PAYLOAD_BYTES + (CHECKSUM_EN ? 1 : 0);
    // Nine bits so a 257-byte packet (255 payload + header + checksum) still indexes cleanly.
    localparam int unsigned IdxW     = 9;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);
    localparam logic [IdxW-1:0] PayIdx  = IdxW'(PAYLOAD_BYTES);
    localparam int unsigned WdogW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit          WdogEn   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
        StRelease = 3'd2,
        StDone    = 3'd3,
        StErr     = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [8*PAYLOAD_BYTES-1:0] data_q, data_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [7:0]                 tx_q, tx_d;
    logic [7:0]                 csum_q, csum_d;
    logic [WdogW-1:0]           wdog_q, wdog_d;
    logic                       us_q, us_d;
    logic                       busy_q, busy_d;
    logic                       sd_q, sd_d;
    logic                       err_q, err_d;
    logic [7:0]                 next_byte;
    logic                       wdog_expired;

    // Byte following the current one: payload byte idx_q, else the accumulated checksum.
    always_comb begin
        next_byte = csum_q;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (idx_q == IdxW'(i)) next_byte = data_q[8*i +: 8];
        end
    end

    assign wdog_expired = WdogEn && (wdog_q == WdogLast);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        csum_d  = csum_q;
        wdog_d  = wdog_q + 1'b1;
        us_d    = us_q;
        busy_d  = busy_q;
        sd_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                wdog_d = '0;
                us_d   = 1'b0;
                busy_d = 1'b0;
                if (send) begin
                    data_d  = data;
                    idx_d   = '0;
                    tx_d    = HEADER;
                    csum_d  = '0;
                    us_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (uart_send_done) begin
                    us_d    = 1'b0;
                    wdog_d  = '0;
                    state_d = StRelease;
                    if (idx_q != '0 && idx_q <= PayIdx) csum_d = csum_q + tx_q;
                end else if (wdog_expired) begin
                    us_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StErr;
                end
            end
            StRelease: begin
                if (!uart_send_done) begin
                    wdog_d = '0;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        sd_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = next_byte;
                        us_d    = 1'b1;
                        state_d = StReq;
                    end
                end else if (wdog_expired) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StErr;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            idx_q   <= '0;
            tx_q    <= '0;
            csum_q  <= '0;
            wdog_q  <= '0;
            us_q    <= 1'b0;
            busy_q  <= 1'b0;
            sd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            csum_q  <= csum_d;
            wdog_q  <= wdog_d;
            us_q    <= us_d;
            busy_q  <= busy_d;
            sd_q    <= sd_d;
            err_q   <= err_d;
        end
    end

    assign busy           = busy_q;
    assign send_done      = sd_q;
    assign error          = err_q;
    assign uart_send      = us_q;
    assign uart_send_data = tx_q;
    assign sta            = {1'b0, state_q};
    assign byte_idx       = idx_q[7:0];

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: dut0 has checksum and a 16-cycle watchdog, dut1 has no
// checksum and no watchdog; both share send/data/rst.
module tb_uart_packet_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        send = 1'b0;
    logic [31:0] data = '0;

    logic       busy0, sd0, er0, us0, usd0;
    logic [7:0] usdat0, bidx0;
    logic [3:0] sta0;
    logic       busy1, sd1, er1, us1, usd1;
    logic [7:0] usdat1, bidx1;
    logic [3:0] sta1;

    int checks = 0;
    int errors = 0;

    // Responder: mode 0 acknowledges combinationally; mode 1 acks after ack_dly cycles and
    // releases one cycle after the request drops. block suppresses the ack of byte 2.
    int   mode = 0;
    int   ack_dly = 2;
    bit   block = 1'b0;
    logic resp = 1'b0;
    int   req_cnt = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       prev0 = 1'b0;
    logic       prev1 = 1'b0;
    int         done_cnt0 = 0;
    int         err_cnt0 = 0;
    int         done_cnt1 = 0;

    assign usd0 = (mode == 0) ? us0 : resp;
    assign usd1 = us1;

    always #5 clk = ~clk;

    uart_packet_tx #(
        .PAYLOAD_BYTES(4),
        .HEADER       (8'hA5),
        .CHECKSUM_EN  (1'b1),
        .TIMEOUT      (16)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .send          (send),
        .data          (data),
        .busy          (busy0),
        .send_done     (sd0),
        .error         (er0),
        .uart_send     (us0),
        .uart_send_data(usdat0),
        .uart_send_done(usd0),
        .sta           (sta0),
        .byte_idx      (bidx0)
    );

    uart_packet_tx #(
        .PAYLOAD_BYTES(4),
        .HEADER       (8'hA5),
        .CHECKSUM_EN  (1'b0),
        .TIMEOUT      (0)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .send          (send),
        .data          (data),
        .busy          (busy1),
        .send_done     (sd1),
        .error         (er1),
        .uart_send     (us1),
        .uart_send_data(usdat1),
        .uart_send_done(usd1),
        .sta           (sta1),
        .byte_idx      (bidx1)
    );

    always @(negedge clk) begin
        if (us0 && !prev0) q0.push_back(usdat0);
        if (us1 && !prev1) q1.push_back(usdat1);
        prev0 = us0;
        prev1 = us1;
        if (sd0) done_cnt0++;
        if (er0) err_cnt0++;
        if (sd1) done_cnt1++;
        if (us0 && !resp) begin
            req_cnt++;
            if (req_cnt >= ack_dly && !(block && bidx0 == 8'd2)) resp = 1'b1;
        end else if (!us0) begin
            resp = 1'b0;
            req_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1, "bench timeout");
    end

    task automatic pulse_send(input logic [31:0] d);
        @(negedge clk);
        send = 1'b1;
        data = d;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic clear_logs();
        q0.delete();
        q1.delete();
        done_cnt0 = 0;
        err_cnt0  = 0;
        done_cnt1 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (sd0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", sd0); end
        checks++; if (er0 !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", er0); end
        checks++; if (us0 !== 1'b0) begin errors++; $display("FAIL reset_uart_send: got %b want 0", us0); end
        checks++; if (usdat0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", usdat0); end
        checks++; if (bidx0 !== 8'h00) begin errors++; $display("FAIL reset_idx: got %0d want 0", bidx0); end
        checks++; if (sta0 !== 4'd0) begin errors++; $display("FAIL reset_sta: got %0d want 0", sta0); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        int n;
        int busy_low;
        exp = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA};
        mode = 1; ack_dly = 2; block = 1'b0;
        clear_logs();
        pulse_send(32'h11223344);
        n = 0; busy_low = 0;
        while (!sd0 && n < 300) begin
            if (!busy0) busy_low++;
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 300) begin errors++; $display("FAIL basic_wait: no send_done within %0d cycles", n); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL basic_busy: busy low %0d cycles, want 0", busy_low); end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt0 != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt0); end
        checks++; if (err_cnt0 != 0) begin errors++; $display("FAIL basic_err_cnt: got %0d want 0", err_cnt0); end
        checks++; if (q0.size() != exp.size()) begin errors++; $display("FAIL basic_len: got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            checks++; if (q0[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, q0[i], exp[i]); end
        end
    endtask

    // The send edge counts as edge 1; send_done must be visible after edge 2N+1 = 13.
    task automatic test_latency();
        int n;
        mode = 0;
        clear_logs();
        @(negedge clk);
        send = 1'b1;
        data = 32'h01020304;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        send = 1'b0;
        while (!sd0 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++; if (n != 13) begin errors++; $display("FAIL latency: send_done after %0d edges, want 13", n); end
        repeat (3) @(negedge clk);
        checks++; if (err_cnt0 != 0) begin errors++; $display("FAIL latency_err: got %0d want 0", err_cnt0); end
        checks++; if (q0.size() != 6 || q0[q0.size()-1] !== 8'h0A) begin
            errors++; $display("FAIL latency_csum: len %0d last %h want len 6 last 0a", q0.size(), (q0.size() > 0) ? q0[q0.size()-1] : 8'hxx);
        end
    endtask

    task automatic test_checksum_wrap();
        logic [7:0] exp0[$];
        logic [7:0] exp1[$];
        int n;
        exp0 = '{8'hA5, 8'h02, 8'h01, 8'hFF, 8'hFF, 8'h01};
        exp1 = '{8'hA5, 8'h02, 8'h01, 8'hFF, 8'hFF};
        mode = 0;
        clear_logs();
        pulse_send(32'hFFFF0102);
        n = 0;
        while (!sd0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (q0.size() != 6) begin errors++; $display("FAIL wrap_len0: got %0d want 6", q0.size()); end
        for (int i = 0; i < exp0.size() && i < q0.size(); i++) begin
            checks++; if (q0[i] !== exp0[i]) begin errors++; $display("FAIL wrap0_byte%0d: got %h want %h", i, q0[i], exp0[i]); end
        end
        checks++; if (q1.size() != 5) begin errors++; $display("FAIL wrap_len1: got %0d want 5", q1.size()); end
        for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
            checks++; if (q1[i] !== exp1[i]) begin errors++; $display("FAIL wrap1_byte%0d: got %h want %h", i, q1[i], exp1[i]); end
        end
        checks++; if (done_cnt1 != 1) begin errors++; $display("FAIL wrap_done1: got %0d want 1", done_cnt1); end
    endtask

    task automatic test_timeout();
        int n;
        int waits;
        mode = 1; ack_dly = 1; block = 1'b1;
        clear_logs();
        pulse_send(32'h55667788);
        n = 0; waits = 0;
        while (!er0 && n < 200) begin
            if (us0 && bidx0 == 8'd2) waits++;
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL to_wait: no error pulse within %0d cycles", n); end
        checks++; if (waits != 16) begin errors++; $display("FAIL to_cycles: waited %0d cycles, want 16", waits); end
        checks++; if (us0 !== 1'b0) begin errors++; $display("FAIL to_uart_send: got %b want 0", us0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy0); end
        checks++; if (sta0 !== 4'd4) begin errors++; $display("FAIL to_sta: got %0d want 4", sta0); end
        block = 1'b0;
        @(negedge clk);
        checks++; if (done_cnt0 != 0) begin errors++; $display("FAIL to_no_done: got %0d want 0", done_cnt0); end
        checks++; if (err_cnt0 != 1) begin errors++; $display("FAIL to_err_cnt: got %0d want 1", err_cnt0); end
        clear_logs();
        pulse_send(32'h01010101);
        checks++; if (bidx0 !== 8'd0 || usdat0 !== 8'hA5 || us0 !== 1'b1) begin
            errors++; $display("FAIL to_restart: idx %0d data %h send %b want 0 a5 1", bidx0, usdat0, us0);
        end
        n = 0;
        while (!sd0 && n < 300) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++; if (q0.size() != 6 || q0[q0.size()-1] !== 8'h04) begin
            errors++; $display("FAIL to_repacket: len %0d last %h want len 6 last 04", q0.size(), (q0.size() > 0) ? q0[q0.size()-1] : 8'hxx);
        end
        checks++; if (done_cnt0 != 1) begin errors++; $display("FAIL to_redone: got %0d want 1", done_cnt0); end
    endtask

    task automatic test_ignore_send();
        logic [7:0] exp[$];
        int n;
        exp = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA};
        mode = 1; ack_dly = 2; block = 1'b0;
        clear_logs();
        pulse_send(32'h11223344);
        repeat (4) @(negedge clk);
        send = 1'b1;
        data = 32'hDEADBEEF;
        @(negedge clk);
        send = 1'b0;
        data = 32'h0;
        n = 0;
        while (!sd0 && n < 300) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt0 != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy0); end
        checks++; if (q0.size() != exp.size()) begin errors++; $display("FAIL ign_len: got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            checks++; if (q0[i] !== exp[i]) begin errors++; $display("FAIL ign_byte%0d: got %h want %h", i, q0[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        int n;
        exp = '{8'hA5, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hEA};
        mode = 1; ack_dly = 2; block = 1'b0;
        clear_logs();
        pulse_send(32'hA1B2C3D4);
        n = 0;
        while (!(us0 && bidx0 == 8'd2 && !resp) && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL mid_reach: byte 2 request not seen"); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy0, sd0, er0, us0} !== 4'b0) begin
            errors++; $display("FAIL mid_flags: busy/done/err/send %b want 0000", {busy0, sd0, er0, us0});
        end
        checks++; if (usdat0 !== 8'h00 || bidx0 !== 8'h00) begin
            errors++; $display("FAIL mid_regs: data %h idx %0d want 00 0", usdat0, bidx0);
        end
        checks++; if (sta0 !== 4'd0) begin errors++; $display("FAIL mid_sta: got %0d want 0", sta0); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (done_cnt0 != 0 || err_cnt0 != 0) begin
            errors++; $display("FAIL mid_pulses: done %0d err %0d want 0 0", done_cnt0, err_cnt0);
        end
        clear_logs();
        pulse_send(32'hA1B2C3D4);
        n = 0;
        while (!sd0 && n < 300) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++; if (done_cnt0 != 1) begin errors++; $display("FAIL mid_redone: got %0d want 1", done_cnt0); end
        checks++; if (q0.size() != exp.size()) begin errors++; $display("FAIL mid_len: got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            checks++; if (q0[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d: got %h want %h", i, q0[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_checksum_wrap();
        test_timeout();
        test_ignore_send();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
